regfile_scan: RTL and testbench

REGFILE_SCAN -- requirements
Module: regfile_scan

---
 rtl/regfile_scan.sv | 131 +++++++++++++
 tb/tb_regfile_scan.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scan.sv
// Register-file scanner: walks a (possibly wrapping) index range, reading one
// register per beat and streaming {index, data, last} over a valid/ready port.
module regfile_scan #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rr,
  input  logic [DATA_W-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] ptr_q,      ptr_d;
  logic [ADDR_W-1:0] last_q,     last_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic [ADDR_W-1:0] idx_q,      idx_d;
  logic              is_last_q,  is_last_d;
  logic              valid_q,    valid_d;
  logic              done_q,     done_d;
  logic              capture;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    data_d    = data_q;
    idx_d     = idx_q;
    is_last_d = is_last_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    capture   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          last_d  = last_reg;
          ptr_d   = first_reg;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // abort wins over a coinciding final handshake and suppresses done
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q && out_ready) begin
          if (is_last_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            capture = 1'b1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // rd is the register addressed by ptr_q (rr), so the beat is snapshotted here
    if (capture) begin
      data_d    = rd;
      idx_d     = ptr_q;
      is_last_d = (ptr_q == last_q);
      valid_d   = 1'b1;
      ptr_d     = ptr_q + ADDR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      last_q    <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      is_last_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      is_last_q <= is_last_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign rr        = ptr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = is_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_scan.sv
// Directed bench for regfile_scan: table of scan vectors plus hand-written
// reset / abort / idle corner sequences against a preloaded register model.
module tb_regfile_scan;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic              abort;
  logic [ADDR_W-1:0] rr;
  logic [DATA_W-1:0] rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rd = regs[rr];

  regfile_scan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .abort     (abort),
    .rr        (rr),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         mode;        // 0 ready high, 1 random ready, 2 stall first beat 4 cycles
    int         abort_after; // 0 = never abort
    bit         restart;     // pulse start while busy
    int         exp_beats;
    int         exp_done;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_val(input logic [4:0] i);
    return 32'(i) * 32'h11;
  endfunction

  task automatic run_vec(input int vn, input vec_t v);
    int          accepted = 0;
    int          n_done = 0;
    int          valid_cycles = 0;
    int          stall_cnt = 0;
    int          budget = 0;
    bit          finished = 0;
    bit          abort_pend = 0;
    bit          restart_pend = 0;
    bit          restarted = 0;
    bit          prev_stall = 0;
    logic [31:0] h_data;
    logic [4:0]  h_idx;
    logic        h_last;
    logic [4:0]  exp_idx;

    start = 1'b1; first_reg = v.first; last_reg = v.last;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_fetch_busy", vn), busy, 1);
    check($sformatf("v%0d_fetch_novalid", vn), out_valid, 0);
    @(negedge clk);
    check($sformatf("v%0d_latency_valid", vn), out_valid, 1);

    while (!finished && budget < 400) begin
      check($sformatf("v%0d_done_excl", vn), done & out_valid, 0);
      if (done) n_done++;
      if (restart_pend) begin
        start = 1'b0; restart_pend = 0;
      end
      if (abort_pend) begin
        abort = 1'b0; abort_pend = 0;
        check($sformatf("v%0d_abort_valid", vn), out_valid, 0);
        check($sformatf("v%0d_abort_busy", vn), busy, 0);
      end
      if (!busy) begin
        finished = 1;
      end else begin
        if (out_valid) valid_cycles++;
        if (prev_stall) begin
          check($sformatf("v%0d_hold_data", vn), out_data, h_data);
          check($sformatf("v%0d_hold_idx", vn), out_idx, h_idx);
          check($sformatf("v%0d_hold_last", vn), out_last, h_last);
        end
        case (v.mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = (stall_cnt >= 4);
        endcase
        if (v.abort_after > 0 && accepted == v.abort_after) begin
          out_ready = 1'b0; abort = 1'b1; abort_pend = 1;
        end
        if (v.restart && accepted == 2 && !restarted) begin
          start = 1'b1; first_reg = 5'd7; last_reg = 5'd9;
          restart_pend = 1; restarted = 1;
        end
        if (out_valid && out_ready) begin
          exp_idx = v.first + 5'(accepted);
          check($sformatf("v%0d_idx", vn), out_idx, exp_idx);
          check($sformatf("v%0d_data", vn), out_data, reg_val(exp_idx));
          check($sformatf("v%0d_last", vn), out_last, exp_idx == v.last);
          regs[out_idx] = reg_val(out_idx);
          accepted++;
        end
        if (out_valid && !out_ready && v.mode == 2) begin
          // overwrite the held register: the captured beat must not follow it
          if (stall_cnt == 0) regs[out_idx] = 32'hDEAD_BEEF;
          stall_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        h_data = out_data; h_idx = out_idx; h_last = out_last;
        @(negedge clk);
        budget++;
      end
    end
    if (!finished) check($sformatf("v%0d_timeout", vn), 1, 0);
    out_ready = 1'b0;
    check($sformatf("v%0d_beats", vn), accepted, v.exp_beats);
    check($sformatf("v%0d_done_cnt", vn), n_done, v.exp_done);
    if (v.mode == 0 && v.abort_after == 0)
      check($sformatf("v%0d_back_to_back", vn), valid_cycles, v.exp_beats);
    if (v.mode == 2) check($sformatf("v%0d_stall_cycles", vn), stall_cnt, 4);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", vn), done, 0);
    check($sformatf("v%0d_idle", vn), busy, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_rr"}, rr, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = reg_val(5'(i));
    vecs[0] = '{5'd0,  5'd31, 0, 0, 1'b0, 32, 1};
    vecs[1] = '{5'd30, 5'd1,  0, 0, 1'b0, 4,  1};
    vecs[2] = '{5'd5,  5'd5,  2, 0, 1'b0, 1,  1};
    vecs[3] = '{5'd0,  5'd31, 1, 0, 1'b0, 32, 1};
    vecs[4] = '{5'd0,  5'd31, 0, 3, 1'b0, 3,  0};
    vecs[5] = '{5'd10, 5'd20, 0, 0, 1'b1, 11, 1};
    vecs[6] = '{5'd31, 5'd31, 0, 0, 1'b0, 1,  1};
    vecs[7] = '{5'd3,  5'd2,  1, 0, 1'b1, 32, 1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_reg = '0; last_reg = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // abort while idle, alone and together with start
    abort = 1'b1;
    @(negedge clk);
    check("idle_abort_busy", busy, 0);
    start = 1'b1; first_reg = 5'd4; last_reg = 5'd6;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    @(negedge clk);
    check("start_abort_valid", out_valid, 0);
    check("start_abort_busy2", busy, 0);

    // reset mid-scan beats a simultaneous start and handshake
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midscan_valid_pre", out_valid, 1);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_zero("midscan_rst");
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end

    // a fresh scan after reset still works
    run_vec(8, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
